sdram_responder: RTL and testbench

- Synthesizable SDRAM device-side responder: the far end of the SDRAM command bus that the SDRAM controller/tester drives.
- Decodes CS/RAS/CAS/WE commands, tracks power-up init, mode register and per-bank open rows, and stores write data in a small on-chip array.
- Returns read data after the programmed CAS latency and flags protocol violations.
- Used in simulation benches and on-FPGA loopback tests of the controller, without external SDRAM.

---
 rtl/sdram_responder.sv | 203 ++++++++++++++++++++
 tb/tb_sdram_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDRAM device-side model: command decode, init tracking, small data array.
// Define SDRAM_TIMING_CHECK_EN to add TRCD/TRP/TRFC/TMRD checking (errCode 5).
module sdram_responder #(
  parameter int MEM_AW = 10,
  parameter int TRCD   = 2,
  parameter int TRP    = 2,
  parameter int TRFC   = 7,
  parameter int TMRD   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sdramCs,
  input  logic        sdramRas,
  input  logic        sdramCas,
  input  logic        sdramWe,
  input  logic [1:0]  sdramDqm,
  input  logic [1:0]  sdramBa,
  input  logic [12:0] sdramA,
  input  logic [15:0] sdramDi,
  output logic [15:0] sdramDo,
  output logic        sdramOe,
  output logic        initDone,
  output logic [1:0]  casLat,
  output logic [3:0]  bankOpen,
  output logic        cmdError,
  output logic [2:0]  errCode
);

  typedef enum logic [2:0] {
    WAIT_PRE, REF1, REF2, WAIT_LMR, READY
  } init_t;

  init_t       state;
  logic [2:0]  rcw;
  logic        nop, act, rd, wr, pre, rfsh, lmr, bst;
  logic        ready, expect_cmd, exec, hit, any_open, ap, cl_ok;
  logic        early;
  logic [2:0]  vcode;
  logic [12:0] row_q [4];
  logic [15:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx;
  logic [15:0] rd_word, rd_mask;
  logic [1:0]  pipe_v;
  logic [15:0] pipe_d0, pipe_d1;

  assign rcw  = {sdramRas, sdramCas, sdramWe};
  assign nop  = sdramCs || rcw == 3'b111;
  assign act  = !sdramCs && rcw == 3'b011;
  assign rd   = !sdramCs && rcw == 3'b101;
  assign wr   = !sdramCs && rcw == 3'b100;
  assign pre  = !sdramCs && rcw == 3'b010;
  assign rfsh = !sdramCs && rcw == 3'b001;
  assign lmr  = !sdramCs && rcw == 3'b000;
  assign bst  = !sdramCs && rcw == 3'b110;

  assign ready    = state == READY;
  assign exec     = ready || expect_cmd;
  assign hit      = bankOpen[sdramBa];
  assign any_open = |bankOpen;
  assign ap       = sdramA[10];
  assign cl_ok    = sdramA[6:4] == 3'b010 || sdramA[6:4] == 3'b011;

  always_comb begin
    expect_cmd = 1'b0;
    case (state)
      WAIT_PRE:   expect_cmd = pre && ap;
      REF1, REF2: expect_cmd = rfsh;
      WAIT_LMR:   expect_cmd = lmr;
      default:    expect_cmd = 1'b0;
    endcase
  end

  // Lowest-numbered violation wins when several occur on one command
  always_comb begin
    vcode = 3'd0;
    if (!ready && !nop && !expect_cmd)
      vcode = 3'd1;
    else if (ready && (rd || wr) && !hit)
      vcode = 3'd2;
    else if (ready && act && hit)
      vcode = 3'd3;
    else if (exec && (lmr || rfsh) && any_open)
      vcode = 3'd4;
    else if (early)
      vcode = 3'd5;
    else if (bst || (exec && lmr && (!cl_ok || sdramA[2:0] != 3'b000)))
      vcode = 3'd6;
  end

  assign idx     = MEM_AW'({sdramBa, row_q[sdramBa], sdramA[8:0]});
  assign rd_word = mem[idx];
  assign rd_mask = {sdramDqm[1] ? 8'h00 : rd_word[15:8],
                    sdramDqm[0] ? 8'h00 : rd_word[7:0]};

`ifdef SDRAM_TIMING_CHECK_EN
  localparam logic [3:0] TRCD_V = 4'(TRCD - 1);
  localparam logic [3:0] TRP_V  = 4'(TRP - 1);
  localparam logic [3:0] TRFC_V = 4'(TRFC - 1);
  localparam logic [3:0] TMRD_V = 4'(TMRD - 1);
  logic [3:0] trcd_q [4];
  logic [3:0] trp_q [4];
  logic [3:0] trfc_q, tmrd_q;

  assign early = exec && !nop &&
    (trfc_q != 0 || tmrd_q != 0 ||
     ((rd || wr) && trcd_q[sdramBa] != 0) ||
     (act && trp_q[sdramBa] != 0));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        trcd_q[i] <= 4'd0;
        trp_q[i]  <= 4'd0;
      end
      trfc_q <= 4'd0;
      tmrd_q <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (trcd_q[i] != 0) trcd_q[i] <= trcd_q[i] - 4'd1;
        if (trp_q[i] != 0)  trp_q[i]  <= trp_q[i] - 4'd1;
      end
      if (trfc_q != 0) trfc_q <= trfc_q - 4'd1;
      if (tmrd_q != 0) tmrd_q <= tmrd_q - 4'd1;
      if (exec) begin
        if (act) trcd_q[sdramBa] <= TRCD_V;
        if ((rd || wr) && hit && ap) trp_q[sdramBa] <= TRP_V;
        if (pre && ap) begin
          for (int i = 0; i < 4; i++) trp_q[i] <= TRP_V;
        end else if (pre) begin
          trp_q[sdramBa] <= TRP_V;
        end
        if (rfsh && !any_open) trfc_q <= TRFC_V;
        if (lmr) tmrd_q <= TMRD_V;
      end
    end
  end
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset && ready && wr && hit) begin
      if (!sdramDqm[0]) mem[idx][7:0]  <= sdramDi[7:0];
      if (!sdramDqm[1]) mem[idx][15:8] <= sdramDi[15:8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= WAIT_PRE;
      sdramDo  <= 16'h0000;
      sdramOe  <= 1'b0;
      initDone <= 1'b0;
      casLat   <= 2'd2;
      bankOpen <= 4'h0;
      cmdError <= 1'b0;
      errCode  <= 3'd0;
      pipe_v   <= 2'b00;
      pipe_d0  <= 16'h0000;
      pipe_d1  <= 16'h0000;
    end else begin
      if (!cmdError && vcode != 3'd0) begin
        cmdError <= 1'b1;
        errCode  <= vcode;
      end
      initDone <= ready;
      if (expect_cmd) begin
        case (state)
          WAIT_PRE: state <= REF1;
          REF1:     state <= REF2;
          REF2:     state <= WAIT_LMR;
          WAIT_LMR: state <= READY;
          default:  state <= state;
        endcase
      end

      // Read pipeline: stage 0 is loaded at the READ edge
      pipe_v[0] <= ready && rd && hit;
      pipe_d0   <= rd_mask;
      pipe_v[1] <= pipe_v[0];
      pipe_d1   <= pipe_d0;
      if (casLat == 2'd3) begin
        sdramOe <= pipe_v[1];
        sdramDo <= pipe_v[1] ? pipe_d1 : 16'h0000;
      end else begin
        sdramOe <= pipe_v[0];
        sdramDo <= pipe_v[0] ? pipe_d0 : 16'h0000;
      end

      if (exec) begin
        if (act) begin
          row_q[sdramBa]    <= sdramA;
          bankOpen[sdramBa] <= 1'b1;
        end
        if ((rd || wr) && hit && ap) bankOpen[sdramBa] <= 1'b0;
        if (pre && ap) bankOpen <= 4'h0;
        else if (pre) bankOpen[sdramBa] <= 1'b0;
        if (lmr && cl_ok) casLat <= sdramA[5:4] == 2'b11 ? 2'd3 : 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init, CL2/CL3 reads, DQM, errors.
module tb_sdram_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        sdramCs, sdramRas, sdramCas, sdramWe;
  logic [1:0]  sdramDqm, sdramBa;
  logic [12:0] sdramA;
  logic [15:0] sdramDi, sdramDo;
  logic        sdramOe, initDone, cmdError;
  logic [1:0]  casLat;
  logic [3:0]  bankOpen;
  logic [2:0]  errCode;
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LMR = 3'b000;

  sdram_responder dut (
    .clock(clock), .reset(reset),
    .sdramCs(sdramCs), .sdramRas(sdramRas),
    .sdramCas(sdramCas), .sdramWe(sdramWe),
    .sdramDqm(sdramDqm), .sdramBa(sdramBa),
    .sdramA(sdramA), .sdramDi(sdramDi),
    .sdramDo(sdramDo), .sdramOe(sdramOe),
    .initDone(initDone), .casLat(casLat),
    .bankOpen(bankOpen), .cmdError(cmdError),
    .errCode(errCode)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] c, input logic [1:0] ba,
                       input logic [12:0] a, input logic [1:0] dqm,
                       input logic [15:0] di);
    sdramCs = 1'b0;
    {sdramRas, sdramCas, sdramWe} = c;
    sdramBa = ba;
    sdramA = a;
    sdramDqm = dqm;
    sdramDi = di;
    @(posedge clock);
    #1;
    {sdramRas, sdramCas, sdramWe} = C_NOP;
    sdramDqm = 2'b00;
  endtask

  task automatic nops(input int n);
    repeat (n) issue(C_NOP, 2'd0, 13'd0, 2'b00, 16'd0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    nops(2);
    reset = 1'b0;
  endtask

  task automatic do_init(input logic [12:0] mode);
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    nops(4);
    issue(C_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    nops(7);
    issue(C_REF, 2'd0, 13'd0, 2'b00, 16'd0);
    nops(7);
    issue(C_LMR, 2'd0, mode, 2'b00, 16'd0);
    nops(1);
  endtask

  task automatic read_chk(input string tag, input logic [1:0] ba,
                          input logic [12:0] a, input logic [1:0] dqm,
                          input int cl, input logic [15:0] exp);
    issue(C_RD, ba, a, dqm, 16'd0);
    repeat (cl - 2) begin
      nops(1);
      chk({tag, " oe early"}, 32'(sdramOe), 32'd0);
    end
    nops(1);
    chk({tag, " oe"}, 32'(sdramOe), 32'd1);
    chk({tag, " do"}, 32'(sdramDo), 32'(exp));
    nops(1);
    chk({tag, " oe drop"}, 32'(sdramOe), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    sdramCs = 1'b1;
    {sdramRas, sdramCas, sdramWe} = C_NOP;
    sdramDqm = 2'b00;
    sdramBa = 2'd0;
    sdramA = 13'd0;
    sdramDi = 16'd0;
    do_reset;
    chk("rst oe", 32'(sdramOe), 32'd0);
    chk("rst do", 32'(sdramDo), 32'd0);
    chk("rst initDone", 32'(initDone), 32'd0);
    chk("rst casLat", 32'(casLat), 32'd2);
    chk("rst bankOpen", 32'(bankOpen), 32'd0);
    chk("rst cmdError", 32'(cmdError), 32'd0);
    chk("rst errCode", 32'(errCode), 32'd0);

    do_init(13'h020);
    chk("init done", 32'(initDone), 32'd1);
    chk("init casLat", 32'(casLat), 32'd2);
    chk("init err", 32'(cmdError), 32'd0);

    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    chk("act open", 32'(bankOpen), 32'h1);
    nops(2);
    issue(C_WR, 2'd0, 13'h405, 2'b00, 16'h1234);
    chk("wr autopre", 32'(bankOpen), 32'h0);
    nops(4);
    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    nops(2);
    read_chk("cl2", 2'd0, 13'h405, 2'b00, 2, 16'h1234);

    issue(C_LMR, 2'd0, 13'h030, 2'b00, 16'd0);
    chk("cl3 casLat", 32'(casLat), 32'd3);
    nops(1);
    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    nops(2);
    read_chk("cl3", 2'd0, 13'h405, 2'b00, 3, 16'h1234);
    chk("cl3 err", 32'(cmdError), 32'd0);

    issue(C_ACT, 2'd1, 13'd3, 2'b00, 16'd0);
    nops(2);
    issue(C_WR, 2'd1, 13'd9, 2'b00, 16'hFFFF);
    nops(1);
    issue(C_WR, 2'd1, 13'd9, 2'b10, 16'h00AB);
    nops(1);
    read_chk("dqm00", 2'd1, 13'd9, 2'b00, 3, 16'hFFAB);
    read_chk("dqm01", 2'd1, 13'd9, 2'b01, 3, 16'hFF00);
    chk("dqm err", 32'(cmdError), 32'd0);
    issue(C_PRE, 2'd0, 13'h400, 2'b00, 16'd0);
    chk("pre all", 32'(bankOpen), 32'h0);
    nops(2);

    issue(C_RD, 2'd2, 13'd0, 2'b00, 16'd0);
    chk("closed cmdError", 32'(cmdError), 32'd1);
    chk("closed errCode", 32'(errCode), 32'd2);
    nops(3);
    chk("closed no data", 32'(sdramOe), 32'd0);

    do_reset;
    do_init(13'h030);
    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    nops(2);
    issue(C_RD, 2'd0, 13'd5, 2'b00, 16'd0);
    reset = 1'b1;
    nops(2);
    chk("midrd oe", 32'(sdramOe), 32'd0);
    chk("midrd do", 32'(sdramDo), 32'd0);
    chk("midrd initDone", 32'(initDone), 32'd0);
    reset = 1'b0;

    do_init(13'h020);
    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    read_chk("early rd", 2'd0, 13'd5, 2'b00, 2, 16'h1234);
`ifdef SDRAM_TIMING_CHECK_EN
    chk("trcd cmdError", 32'(cmdError), 32'd1);
    chk("trcd errCode", 32'(errCode), 32'd5);
`else
    chk("trcd cmdError", 32'(cmdError), 32'd0);
    chk("trcd errCode", 32'(errCode), 32'd0);
`endif
    nops(2);

    do_reset;
    issue(C_ACT, 2'd0, 13'd0, 2'b00, 16'd0);
    chk("order errCode", 32'(errCode), 32'd1);
    chk("order bankOpen", 32'(bankOpen), 32'd0);

    do_reset;
    do_init(13'h040);
    chk("badcl errCode", 32'(errCode), 32'd6);
    chk("badcl casLat", 32'(casLat), 32'd2);
    chk("badcl initDone", 32'(initDone), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
